ov7670_rgb444_capture: RTL and testbench
========================================

# ov7670_rgb444_capture

Capture front end for the camera path. Sits directly upstream of the per-pixel colour filters. Assembles the OV7670's two-byte RGB444 stream into 12-bit `{R,G,B}` pixels, the same format the filters take on `pixel_in`, and generates the frame-buffer write address and write strobe. The pixel flows capture → filter → frame-buffer BRAM write port, with `addr`/`we` running alongside the filter.

## Interface
- `H_ACTIVE`, 320, pixels stored per line
- `V_ACTIVE`, 240, lines stored per frame
- `ADDR_W`, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE
- `clk`  in  1  camera pixel clock (PCLK); one byte per rising edge while `href`=1
- `rst`  in  1  synchronous, active-high reset
- `vsync`  in  1  camera frame sync; high = vertical blanking
- `href`  in  1  camera line valid; high = byte on `d` is active data
- `d`  in  8  camera data byte
- `pixel_out`  out  12  assembled pixel `{R[3:0],G[3:0],B[3:0]}`
- `addr`  out  ADDR_W  frame-buffer address for `pixel_out`
- `we`  out  1  write strobe; `pixel_out`/`addr` are valid only when `we`=1
- `frame_done`  out  1  one-cycle pulse at the end of a captured frame

## Operation
- **Byte format per pixel:**
  - byte 0 = `xxxxRRRR`; keep `d[3:0]` as red.
  - byte 1 = `GGGGBBBB`; `pixel_out` = `{red, d[7:4], d[3:0]}`.
- **State machine:** WAIT_VS, WAIT_START, ACTIVE.
  - WAIT_VS: wait for `vsync`=1, then go to WAIT_START. Entered on reset, which discards any partial frame in progress.
  - WAIT_START: wait for `vsync`=0, then go to ACTIVE. On entry, clear the x counter, line-base register and y counter.
  - ACTIVE: capture bytes. When `vsync`=1, go to WAIT_START.
    - Pulse `frame_done` if at least one line was stored (y>0).
    - Any half-assembled pixel is dropped.
- **Phase bit:**
  - Toggles on each sampled byte while `href`=1.
  - Forced to 0 whenever `href`=0, so an odd trailing byte is discarded.
- **Counters:**
  - x counts assembled pixels in the current line. It saturates at H_ACTIVE; pixels beyond H_ACTIVE are dropped (`we` stays 0).
  - Line end is the `href` falling edge (href=0 now, href=1 on the previous cycle) when x>0.
    - Sets line_base += H_ACTIVE, y += 1, x = 0.
    - A line with x=0 (href high for ≤1 byte) does not advance y.
  - Lines with y ≥ V_ACTIVE are dropped.
  - Address = line_base + x. No multiplier. Short lines still start the next line at a multiple of H_ACTIVE.
- **Arithmetic:** line_base and the address are ADDR_W bits wide. Under the parameter constraint the address never exceeds H_ACTIVE*V_ACTIVE−1, so it never wraps.
- **Boundary cases:**
  - `vsync`=1 while `href`=1 is treated as frame end; no write occurs in that cycle.
  - `rst` overrides everything in the same cycle.

## Timing
- All outputs are registered.
- **Reset values:** `pixel_out`=0, `addr`=0, `we`=0, `frame_done`=0; state WAIT_VS; phase, x, y, line_base all 0.
- **Pixel latency:** if byte 1 is sampled at edge N, then `we`=1 with `pixel_out` and `addr` valid from edge N until edge N+1.
- `we` is a single-cycle pulse per pixel. At most one write per 2 clocks.
- `addr` and `pixel_out` hold their last values while `we`=0.
- `frame_done` is high for exactly the one cycle after the edge at which the ACTIVE→WAIT_START transition is taken.
- **Downstream handshake:** none. The filters are combinational and the BRAM accepts a write every cycle, so there is no backpressure.

## Test plan
- **Full frame:** after reset, drive one vsync pulse and then 240 lines of 640 bytes (byte pairs 0x0A, 0x5C).
  - Expect exactly 76800 writes of 0xA5C with `addr` 0..76799 in order.
  - Expect a single `frame_done` pulse after the next vsync rise.
- **Mid-frame start:** release reset with `vsync`=0 and lines already flowing.
  - Expect no `we` until vsync goes 1 then 0.
  - The first write is then at `addr`=0.
- **Long line:** 330 pixels (660 bytes) on line 0.
  - Expect 320 writes at addr 0..319.
  - The first pixel of line 1 is written at `addr`=320.
- **Short line and odd byte:** line 0 has 100 pixels plus one extra byte 0x0F, then `href` drops.
  - Expect 100 writes.
  - The stray byte produces no write.
  - The first pixel of line 1 is written at `addr`=320, with its value formed from line 1's bytes only.
- **Reset mid-frame:** assert `rst` for 1 cycle during line 10.
  - Next cycle: `we`=0, `addr`=0, `frame_done`=0.
  - No writes occur until a full vsync high→low sequence completes.
- **Early vsync:** vsync rises after 5 lines.
  - Expect one `frame_done` pulse.
  - The next frame restarts at `addr`=0.
  - Vsync rising before any line is stored produces no `frame_done`.

Source files
------------

// File: rtl/ov7670_rgb444_capture.sv
// rtl/ov7670_rgb444_capture.sv - OV7670 RGB444 byte-pair capture with frame-buffer write addressing
//
// Assembles the camera's two-byte RGB444 stream into 12-bit {R,G,B} pixels and
// produces the frame-buffer write address and strobe for each stored pixel.
//
// Ports:
//   clk        camera pixel clock (PCLK), one byte per rising edge while href=1
//   rst        synchronous active-high reset
//   vsync      camera frame sync, high during vertical blanking
//   href       camera line valid, high when d carries active data
//   d          camera data byte
//   pixel_out  assembled pixel {R[3:0],G[3:0],B[3:0]}, valid when we=1
//   addr       frame-buffer address for pixel_out, valid when we=1
//   we         single-cycle write strobe per stored pixel
//   frame_done one-cycle pulse after a frame that stored at least one line
module ov7670_rgb444_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [11:0]       pixel_out,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              frame_done
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS    = 2'd0,
    WAIT_START = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              phase;
  logic [3:0]        red;
  logic              href_d;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] line_base;

  logic capture;
  logic store;
  logic line_end;
  logic frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_VS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    store     = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    case (state)
      WAIT_VS: begin
        if (vsync) state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (!vsync) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (vsync) begin
          // vsync wins over href: a byte arriving with vsync high is never stored
          state_nxt = WAIT_START;
          frame_end = 1'b1;
        end else begin
          capture  = href && phase;
          store    = capture && (x != X_MAX) && (y < Y_MAX);
          // a line ends on the href falling edge, but only if it produced a pixel
          line_end = !href && href_d && (x != '0);
        end
      end
      default: state_nxt = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= 1'b0;
      red        <= '0;
      href_d     <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      pixel_out  <= '0;
      addr       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      href_d     <= href;
      we         <= store;
      frame_done <= frame_end && (y != '0);

      // pixel_out/addr only move on a store so they hold between writes
      if (store) begin
        pixel_out <= {red, d};
        addr      <= line_base + ADDR_W'(x);
      end

      if (state != ACTIVE) begin
        phase <= 1'b0;
        if (state == WAIT_START) begin
          x         <= '0;
          y         <= '0;
          line_base <= '0;
        end
      end else if (vsync) begin
        phase <= 1'b0;
      end else if (href) begin
        phase <= ~phase;
        if (!phase) begin
          red <= d[3:0];
        end else if (x != X_MAX) begin
          x <= x + 1'b1;
        end
      end else begin
        // dropping href discards any odd trailing byte
        phase <= 1'b0;
        if (line_end) begin
          x <= '0;
          // once past the last stored line, freeze y/line_base so they cannot wrap
          if (y != Y_MAX) begin
            y         <= y + 1'b1;
            line_base <= line_base + LINE_STEP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_rgb444_capture.sv
// tb/tb_ov7670_rgb444_capture.sv - self-checking bench for ov7670_rgb444_capture
module tb_ov7670_rgb444_capture;

  localparam int H  = 20;
  localparam int V  = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          href;
  logic [7:0]    d;
  logic [11:0]   pixel_out;
  logic [AW-1:0] addr;
  logic          we;
  logic          frame_done;

  ov7670_rgb444_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .pixel_out (pixel_out),
    .addr      (addr),
    .we        (we),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int pix;
    int cyc;
  } wr_t;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   cyc      = 0;
  int   fd_cnt   = 0;
  int   exp_fd   = 0;
  int   b2b      = 0;
  logic prev_we  = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;
  int   line_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) got_q.push_back('{int'(addr), int'(pixel_out), cyc});
    if (we && prev_we) b2b++;
    if (frame_done) fd_cnt++;
    prev_we = we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame_begin();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
    armed    = 1'b1;
    line_idx = 0;
  endtask

  task automatic frame_end();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    if (armed && line_idx > 0) exp_fd++;
    armed = 1'b0;
  endtask

  // Drives one line of nbytes bytes and records the writes it should cause:
  // pixel p of stored line L lands at L*H+p with {byte0[3:0], byte1}, on the
  // cycle byte1 is sampled. stop_at cuts the line with vsync or a reset.
  task automatic send_line(int nbytes, bit fixed, int stop_at, bit stop_rst);
    logic [7:0] b;
    logic [3:0] r;
    bit         counts;
    r      = 4'h0;
    counts = armed && (line_idx < V);
    for (int i = 0; i < nbytes; i++) begin
      b    = fixed ? (((i % 2) == 1) ? 8'h5C : 8'h0A) : 8'($urandom);
      d    = b;
      href = 1'b1;
      if (i == stop_at) begin
        if (stop_rst) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check("rst_we", {31'd0, we}, 32'd0);
          check("rst_addr", {24'd0, addr}, 32'd0);
          check("rst_fd", {31'd0, frame_done}, 32'd0);
          check("rst_pix", {20'd0, pixel_out}, 32'd0);
          armed  = 1'b0;
          counts = 1'b0;
        end else begin
          vsync = 1'b1;
          tick();
          href = 1'b0;
          repeat (3) tick();
          if (armed && line_idx > 0) exp_fd++;
          armed = 1'b0;
          return;
        end
      end else begin
        tick();
        if ((i % 2) == 0) r = b[3:0];
        else if (counts && (i / 2) < H)
          exp_q.push_back('{line_idx * H + i / 2, int'({r, b}), cyc});
      end
    end
    href = 1'b0;
    d    = 8'($urandom);
    repeat (4) tick();
    if (armed && nbytes >= 2) line_idx++;
  endtask

  task automatic compare(string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
      check({tag, "_pix"}, got_q[i].pix, exp_q[i].pix);
      check({tag, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
    end
    check({tag, "_fd"}, fd_cnt, exp_fd);
    check({tag, "_b2b"}, b2b, 0);
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
    exp_fd = 0;
    b2b    = 0;
  endtask

  initial begin
    rst   = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    d     = 8'h00;
    repeat (3) tick();
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_addr", {24'd0, addr}, 32'd0);
    check("reset_pix", {20'd0, pixel_out}, 32'd0);
    check("reset_fd", {31'd0, frame_done}, 32'd0);

    // leave reset with vsync low and lines already flowing: nothing stored
    rst = 1'b0;
    repeat (3) send_line(2 * H, 1'b0, -1, 1'b0);
    compare("midstart");

    // full frame of the fixed 0x0A/0x5C pattern
    frame_begin();
    for (int l = 0; l < V; l++) send_line(2 * H, 1'b1, -1, 1'b0);
    frame_end();
    compare("full");

    // long line, short line with odd byte, single-byte line, then overflow lines
    frame_begin();
    send_line(2 * (H + 5), 1'b0, -1, 1'b0);
    send_line(2 * 7 + 1, 1'b0, -1, 1'b0);
    send_line(1, 1'b0, -1, 1'b0);
    for (int l = 0; l < V + 1; l++)
      send_line(2 * int'($urandom_range(1, H + 2)) + int'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
    frame_end();
    compare("mixed");

    // reset pulse during line 10, then lines with no vsync: nothing stored
    frame_begin();
    for (int l = 0; l < 10; l++) send_line(2 * H, 1'b0, -1, 1'b0);
    send_line(2 * H, 1'b0, 13, 1'b1);
    repeat (2) send_line(2 * H, 1'b0, -1, 1'b0);
    compare("rst_mid");

    frame_begin();
    repeat (3) send_line(2 * H, 1'b0, -1, 1'b0);
    frame_end();
    compare("after_rst");

    // vsync rises mid-line after 5 lines, on a second byte
    frame_begin();
    repeat (5) send_line(2 * H, 1'b0, -1, 1'b0);
    send_line(2 * H, 1'b0, 7, 1'b0);
    compare("early_vs");

    frame_begin();
    send_line(2 * H, 1'b0, -1, 1'b0);
    frame_end();
    compare("restart");

    // no line stored before vsync: no frame_done
    frame_begin();
    frame_end();
    compare("empty");

    frame_begin();
    send_line(10, 1'b0, 6, 1'b0);
    compare("partial");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
